// File: rtl/half_adder_pkg.sv
// Shared helpers for the half-adder pipe: carry-count width and lane popcount.
package half_adder_pkg;

    localparam int unsigned MAX_WIDTH = 64;
    localparam int unsigned POP_W     = 7;

    function automatic int unsigned carry_width(input int unsigned width);
        int unsigned cw;
        cw = $clog2(width + 32'd1);
        return (cw == 32'd0) ? 32'd1 : cw;
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_WIDTH-1:0] v);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(MAX_WIDTH); i++) begin
            cnt = cnt + POP_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Single-bit half adder: sum = a ^ b, carry = a & b.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/half_adder_pipe.sv
// WIDTH independent half-adder lanes with carry summary and an optional
// one-cycle output register stage qualified by out_valid.
module half_adder_pipe
    import half_adder_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned OUT_REG = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [WIDTH-1:0]                 a,
    input  logic [WIDTH-1:0]                 b,
    output logic                             out_valid,
    output logic [WIDTH-1:0]                 sum,
    output logic [WIDTH-1:0]                 carry,
    output logic                             carry_any,
    output logic [carry_width(WIDTH)-1:0]    carry_cnt
);

    localparam int unsigned CW = carry_width(WIDTH);

    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] carry_c;
    logic             any_c;
    logic [CW-1:0]    cnt_c;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_lane
        half_adder_cell u_cell (
            .a     (a[i]),
            .b     (b[i]),
            .sum   (sum_c[i]),
            .carry (carry_c[i])
        );
    end

    assign any_c = |carry_c;
    assign cnt_c = CW'(popcount(MAX_WIDTH'(carry_c)));

    if (OUT_REG != 0) begin : g_reg
        logic             valid_d, valid_q;
        logic [WIDTH-1:0] sum_d,   sum_q;
        logic [WIDTH-1:0] carry_d, carry_q;
        logic             any_d,   any_q;
        logic [CW-1:0]    cnt_d,   cnt_q;

        // Data registers only load on a valid operand pair; otherwise hold.
        always_comb begin
            valid_d = in_valid;
            sum_d   = sum_q;
            carry_d = carry_q;
            any_d   = any_q;
            cnt_d   = cnt_q;
            if (in_valid) begin
                sum_d   = sum_c;
                carry_d = carry_c;
                any_d   = any_c;
                cnt_d   = cnt_c;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
                carry_q <= '0;
                any_q   <= 1'b0;
                cnt_q   <= '0;
            end else begin
                valid_q <= valid_d;
                sum_q   <= sum_d;
                carry_q <= carry_d;
                any_q   <= any_d;
                cnt_q   <= cnt_d;
            end
        end

        assign out_valid = valid_q;
        assign sum       = sum_q;
        assign carry     = carry_q;
        assign carry_any = any_q;
        assign carry_cnt = cnt_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign out_valid = in_valid;
        assign sum       = sum_c;
        assign carry     = carry_c;
        assign carry_any = any_c;
        assign carry_cnt = cnt_c;
    end

endmodule

// File: tb/tb_half_adder_pipe.sv
// Self-checking bench for half_adder_pipe across several WIDTH/OUT_REG builds.
module tb_half_adder_pipe;

    logic clk;
    logic rst_n;

    int checks;
    int failures;

    logic       iv8,  iv4,  iv1,  iv4c;
    logic [7:0] a8,   b8;
    logic [3:0] a4,   b4,   a4c,  b4c;
    logic       a1,   b1;

    logic       ov8,  ov4,  ov1,  ov4c;
    logic [7:0] s8,   c8;
    logic [3:0] s4,   c4,   s4c,  c4c;
    logic       s1,   c1;
    logic       any8, any4, any1, any4c;
    logic [3:0] cnt8;
    logic [2:0] cnt4, cnt4c;
    logic [0:0] cnt1;

    half_adder_pipe #(.WIDTH(8), .OUT_REG(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8),
        .out_valid(ov8), .sum(s8), .carry(c8), .carry_any(any8), .carry_cnt(cnt8));
    half_adder_pipe #(.WIDTH(4), .OUT_REG(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .a(a4), .b(b4),
        .out_valid(ov4), .sum(s4), .carry(c4), .carry_any(any4), .carry_cnt(cnt4));
    half_adder_pipe #(.WIDTH(1), .OUT_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1),
        .out_valid(ov1), .sum(s1), .carry(c1), .carry_any(any1), .carry_cnt(cnt1));
    half_adder_pipe #(.WIDTH(4), .OUT_REG(0)) dut4c (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4c), .a(a4c), .b(b4c),
        .out_valid(ov4c), .sum(s4c), .carry(c4c), .carry_any(any4c), .carry_cnt(cnt4c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each lane adds two bits arithmetically; result bit 0 is sum, bit 1 is carry.
    function automatic void model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                  output logic [63:0] s, output logic [63:0] c,
                                  output int cnt);
        s = '0; c = '0; cnt = 0;
        for (int i = 0; i < w; i++) begin
            int t;
            t = int'(av[i]) + int'(bv[i]);
            s[i] = (t % 2) == 1;
            c[i] = (t / 2) == 1;
            cnt += t / 2;
        end
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic [7:0] carry;
        logic       any;
        int         cnt;
    } vec8_t;

    vec8_t tbl[6];

    logic [63:0] es, ec;
    int          ecnt;
    logic        ev;
    logic [63:0] hs, hc;
    int          hcnt;

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        iv8 = 0; iv4 = 0; iv1 = 0; iv4c = 0;
        a8 = 0; b8 = 0; a4 = 0; b4 = 0; a1 = 0; b1 = 0; a4c = 0; b4c = 0;

        tbl[0] = '{8'hF0, 8'hCC, 8'h3C, 8'hC0, 1'b1, 2};
        tbl[1] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1, 8};
        tbl[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0};
        tbl[3] = '{8'h0F, 8'h01, 8'h0E, 8'h01, 1'b1, 1};
        tbl[4] = '{8'hAA, 8'h55, 8'hFF, 8'h00, 1'b0, 0};
        tbl[5] = '{8'h81, 8'h81, 8'h00, 8'h81, 1'b1, 2};

        // Reset values.
        #12;
        check("rst8_valid", 64'(ov8), 64'd0);
        check("rst8_sum",   64'(s8),  64'd0);
        check("rst8_carry", 64'(c8),  64'd0);
        check("rst8_any",   64'(any8), 64'd0);
        check("rst8_cnt",   64'(cnt8), 64'd0);
        check("rst1_valid", 64'(ov1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors on the 8-lane registered build, back-to-back.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            a8 = tbl[k].a; b8 = tbl[k].b; iv8 = 1'b1;
            @(posedge clk); #1;
            check($sformatf("tbl%0d_valid", k), 64'(ov8),  64'd1);
            check($sformatf("tbl%0d_sum", k),   64'(s8),   64'(tbl[k].sum));
            check($sformatf("tbl%0d_carry", k), 64'(c8),   64'(tbl[k].carry));
            check($sformatf("tbl%0d_any", k),   64'(any8), 64'(tbl[k].any));
            check($sformatf("tbl%0d_cnt", k),   64'(cnt8), 64'(tbl[k].cnt));
        end

        // 1-lane build: 00,01,10,11 on consecutive cycles.
        for (int k = 0; k < 4; k++) begin
            logic [1:0] ab;
            ab = 2'(k);
            @(negedge clk);
            a1 = ab[1]; b1 = ab[0]; iv1 = 1'b1;
            @(posedge clk); #1;
            check($sformatf("w1_%0d_valid", k), 64'(ov1), 64'd1);
            check($sformatf("w1_%0d_sum", k),   64'(s1),  (k == 1 || k == 2) ? 64'd1 : 64'd0);
            check($sformatf("w1_%0d_carry", k), 64'(c1),  (k == 3) ? 64'd1 : 64'd0);
            check($sformatf("w1_%0d_cnt", k),   64'(cnt1), (k == 3) ? 64'd1 : 64'd0);
        end
        @(negedge clk);
        iv1 = 1'b0;

        // Hold: load 0F/01 then idle with noisy operands.
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h01; iv8 = 1'b1;
        @(posedge clk); #1;
        check("hold_load_sum", 64'(s8), 64'h0E);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
            @(posedge clk); #1;
            check($sformatf("hold%0d_valid", k), 64'(ov8),  64'd0);
            check($sformatf("hold%0d_sum", k),   64'(s8),   64'h0E);
            check($sformatf("hold%0d_carry", k), 64'(c8),   64'h01);
            check($sformatf("hold%0d_cnt", k),   64'(cnt8), 64'd1);
        end

        // Randomized stream against the reference model.
        ev = 1'b0; hs = 64'h0E; hc = 64'h01; hcnt = 1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            iv8 = 1'($urandom_range(0, 2) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom);
            ev = iv8;
            if (iv8) begin
                model(8, 64'(a8), 64'(b8), es, ec, ecnt);
                hs = es; hc = ec; hcnt = ecnt;
            end
            @(posedge clk); #1;
            check("rnd_valid", 64'(ov8),  64'(ev));
            check("rnd_sum",   64'(s8),   hs);
            check("rnd_carry", 64'(c8),   hc);
            check("rnd_any",   64'(any8), 64'(hcnt != 0));
            check("rnd_cnt",   64'(cnt8), 64'(hcnt));
        end
        @(negedge clk);
        iv8 = 1'b0;

        // Asynchronous reset mid-stream on the 4-lane build.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            iv4 = 1'b1; a4 = 4'hF; b4 = 4'($urandom) | 4'h1;
        end
        @(posedge clk); #1;
        check("pre_rst4_valid", 64'(ov4), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst4_valid", 64'(ov4),  64'd0);
        check("arst4_sum",   64'(s4),   64'd0);
        check("arst4_carry", 64'(c4),   64'd0);
        check("arst4_any",   64'(any4), 64'd0);
        check("arst4_cnt",   64'(cnt4), 64'd0);
        @(posedge clk); #1;
        check("arst4_held_valid", 64'(ov4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a4 = 4'hA; b4 = 4'h6; iv4 = 1'b1;
        @(posedge clk); #1;
        check("post_rst4_valid", 64'(ov4),  64'd1);
        check("post_rst4_sum",   64'(s4),   64'hC);
        check("post_rst4_carry", 64'(c4),   64'h2);
        check("post_rst4_cnt",   64'(cnt4), 64'd1);
        @(negedge clk);
        iv4 = 1'b0;

        // Combinational build: same-delta response.
        a4c = 4'h5; b4c = 4'h3; iv4c = 1'b1;
        #1;
        check("comb_valid", 64'(ov4c),  64'd1);
        check("comb_sum",   64'(s4c),   64'h6);
        check("comb_carry", 64'(c4c),   64'h1);
        check("comb_any",   64'(any4c), 64'd1);
        check("comb_cnt",   64'(cnt4c), 64'd1);
        iv4c = 1'b0;
        #1;
        check("comb_drop_valid", 64'(ov4c), 64'd0);
        for (int k = 0; k < 20; k++) begin
            a4c = 4'($urandom); b4c = 4'($urandom); iv4c = 1'($urandom);
            model(4, 64'(a4c), 64'(b4c), es, ec, ecnt);
            #1;
            check("comb_rnd_valid", 64'(ov4c),  64'(iv4c));
            check("comb_rnd_sum",   64'(s4c),   es);
            check("comb_rnd_carry", 64'(c4c),   ec);
            check("comb_rnd_cnt",   64'(cnt4c), 64'(ecnt));
        end

        // 1-lane zero result must be distinguishable from idle.
        @(posedge clk); #1;
        check("w1_idle_valid", 64'(ov1), 64'd0);
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b0; iv1 = 1'b1;
        @(posedge clk); #1;
        check("w1_zero_valid", 64'(ov1),  64'd1);
        check("w1_zero_sum",   64'(s1),   64'd0);
        check("w1_zero_carry", 64'(c1),   64'd0);
        check("w1_zero_any",   64'(any1), 64'd0);
        @(negedge clk);
        iv1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/half_adder_pipe.md
Name: half_adder_pipe

Overview:
- Vector of WIDTH independent half-adder lanes: per lane, sum = a XOR b and carry = a AND b.
- Optional output register stage with a valid qualifier, plus a lane-carry summary (any / count).
- Used as a leaf arithmetic primitive feeding ripple/carry-save adders and carry-detect logic.
- One clock domain; no backpressure.

Parameters:
- WIDTH, 1, number of independent lanes; legal range 1..64.
- OUT_REG, 1, 1 = all outputs registered (latency 1 cycle); 0 = all outputs combinational (latency 0).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a/b carry a new operand pair this cycle.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- out_valid  output  1  sum/carry/carry_any/carry_cnt hold a result.
- sum  output  WIDTH  per-lane a^b.
- carry  output  WIDTH  per-lane a&b.
- carry_any  output  1  OR of all carry bits.
- carry_cnt  output  CW  number of lanes with carry=1; CW = $clog2(WIDTH+1), minimum 1.

Behaviour:
- Reset and clocking: one clock (clk); reset is asynchronous and active-low (rst_n). Assertion clears all registers immediately, independent of clk.
- Lane function, unsigned, no inter-lane carry:
  - a=0,b=0 -> sum 0, carry 0
  - a=0,b=1 -> sum 1, carry 0
  - a=1,b=0 -> sum 1, carry 0
  - a=1,b=1 -> sum 0, carry 1
- Summary outputs:
  - carry_any = |carry.
  - carry_cnt = popcount(carry), zero-extended to CW bits; maximum value WIDTH, never wraps.
- OUT_REG=1:
  - Reset values: out_valid 0, sum 0, carry 0, carry_any 0, carry_cnt 0.
  - On a clk edge with in_valid=1: register sum, carry, carry_any and carry_cnt computed from the current a/b; out_valid <= 1.
  - On a clk edge with in_valid=0: out_valid <= 0; data registers hold their last value.
  - Latency is exactly 1 cycle; back-to-back in_valid gives one result per cycle.
  - Reset asserted mid-stream discards the in-flight result. After rst_n deasserts, the first edge with in_valid=1 produces the next result.
- OUT_REG=0:
  - out_valid = in_valid; all data outputs are pure combinational functions of a/b.
  - clk and rst_n are unused; no reset value applies.
- a/b with in_valid=0 are don't-care and must not disturb registered outputs.
- No X propagation from unused lanes: all lanes are always computed.

Decomposition:
- Shared package, half_adder_pkg:
  - function carry_width(WIDTH) returning $clog2(WIDTH+1) clamped to >=1.
  - popcount function.
- Sub-module half_adder_cell: 1-bit combinational cell (a, b -> sum, carry), instantiated WIDTH times via generate.
- Top handles the register stage, carry_any and carry_cnt.

Test Plan:
- WIDTH=1, OUT_REG=1, in_valid=1, (a,b) stepped 00,01,10,11 on consecutive cycles -> one cycle later (sum,carry) = 00,10,10,01; out_valid high for 4 cycles; carry_cnt = 0,0,0,1.
- WIDTH=8, a=8'hF0, b=8'hCC, in_valid=1 -> next cycle sum=8'h3C, carry=8'hC0, carry_any=1, carry_cnt=2. Then a=8'hFF, b=8'hFF -> carry=8'hFF, carry_cnt=8 (CW=4).
- WIDTH=8, load a=8'h0F, b=8'h01, then hold in_valid=0 and toggle a/b randomly for 5 cycles -> sum stays 8'h0E, carry stays 8'h01, out_valid=0.
- WIDTH=4, continuous stream; assert rst_n=0 between clock edges -> all outputs 0 immediately (asynchronous). Release, then a=4'hA, b=4'h6 -> next cycle sum=4'hC, carry=4'h2, carry_cnt=1.
- WIDTH=4, OUT_REG=0, a=4'h5, b=4'h3, in_valid=1 -> same delta cycle sum=4'h6, carry=4'h1, carry_any=1, out_valid=1; drop in_valid -> out_valid=0 immediately.
- WIDTH=1, a=b=0 with in_valid=1 after reset -> out_valid=1 with all data 0; this case must be distinguishable from the idle state via out_valid.
